// File: rtl/screen_pkg.sv
// Shared constants and the bitmap address map for the 128x128 monochrome screen.
// The HP-bar writer also uses this package, so both sides agree on the byte layout.
package screen_pkg;

    localparam int SCR_W         = 128;
    localparam int SCR_H         = 128;
    localparam int BYTES_PER_ROW = 16;
    localparam int RAM_AW        = 11;
    localparam int RAM_DW        = 8;

    // Wide enough for the default 800x525 raster.
    localparam int CNT_W = 11;

    localparam int DEF_H_ACTIVE = 640;
    localparam int DEF_H_FP     = 16;
    localparam int DEF_H_SYNC   = 96;
    localparam int DEF_H_BP     = 48;
    localparam int DEF_V_ACTIVE = 480;
    localparam int DEF_V_FP     = 10;
    localparam int DEF_V_SYNC   = 2;
    localparam int DEF_V_BP     = 33;

    // Timing flags travelling alongside the RAM fetch so pins stay aligned.
    typedef struct packed {
        logic       hs;
        logic       vs;
        logic       de;
        logic       win;
        logic       first;
        logic [2:0] bit_idx;
    } scan_tag_t;

    // Syncs idle high, everything else inactive.
    localparam scan_tag_t TAG_IDLE = '{hs: 1'b1, vs: 1'b1, de: 1'b0, win: 1'b0,
                                       first: 1'b0, bit_idx: 3'd0};

    // Byte address of screen pixel (x, y): y*16 + x/8, truncated to the RAM width.
    function automatic logic [RAM_AW-1:0] scr_addr(input logic [CNT_W-1:0] y,
                                                   input logic [CNT_W-1:0] x);
        return RAM_AW'((y << 4) + (x >> 3));
    endfunction

endpackage

// File: rtl/vga_timing_gen.sv
// Free-running VGA raster counters with raw (undelayed) sync and active-video flags.
module vga_timing_gen
    import screen_pkg::*;
#(
    parameter int H_ACTIVE = DEF_H_ACTIVE,
    parameter int H_FP     = DEF_H_FP,
    parameter int H_SYNC   = DEF_H_SYNC,
    parameter int H_BP     = DEF_H_BP,
    parameter int V_ACTIVE = DEF_V_ACTIVE,
    parameter int V_FP     = DEF_V_FP,
    parameter int V_SYNC   = DEF_V_SYNC,
    parameter int V_BP     = DEF_V_BP
) (
    input  logic             clk,
    input  logic             rst,
    output logic [CNT_W-1:0] h_cnt,
    output logic [CNT_W-1:0] v_cnt,
    output logic             hs_raw,
    output logic             vs_raw,
    output logic             de_raw
);

    localparam logic [CNT_W-1:0] H_LAST   = CNT_W'(H_ACTIVE + H_FP + H_SYNC + H_BP - 1);
    localparam logic [CNT_W-1:0] V_LAST   = CNT_W'(V_ACTIVE + V_FP + V_SYNC + V_BP - 1);
    localparam logic [CNT_W-1:0] H_ACT    = CNT_W'(H_ACTIVE);
    localparam logic [CNT_W-1:0] V_ACT    = CNT_W'(V_ACTIVE);
    localparam logic [CNT_W-1:0] HS_FIRST = CNT_W'(H_ACTIVE + H_FP);
    localparam logic [CNT_W-1:0] HS_LAST  = CNT_W'(H_ACTIVE + H_FP + H_SYNC - 1);
    localparam logic [CNT_W-1:0] VS_FIRST = CNT_W'(V_ACTIVE + V_FP);
    localparam logic [CNT_W-1:0] VS_LAST  = CNT_W'(V_ACTIVE + V_FP + V_SYNC - 1);

    // Pixel counter wraps every line; line counter advances on each pixel wrap.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            h_cnt <= '0;
            v_cnt <= '0;
        end else if (h_cnt == H_LAST) begin
            h_cnt <= '0;
            v_cnt <= (v_cnt == V_LAST) ? '0 : v_cnt + 1'b1;
        end else begin
            h_cnt <= h_cnt + 1'b1;
        end
    end

    assign hs_raw = !((h_cnt >= HS_FIRST) && (h_cnt <= HS_LAST));
    assign vs_raw = !((v_cnt >= VS_FIRST) && (v_cnt <= VS_LAST));
    assign de_raw = (h_cnt < H_ACT) && (v_cnt < V_ACT);

endmodule

// File: rtl/screen_scan.sv
// Scans the 128x128 display RAM into a window of the VGA raster.
// Counter -> RAM request (1 clk) -> RAM data (2 clks) -> registered pins (3 clks);
// the timing flags ride a matching two-stage delay so everything lands together.
module screen_scan
    import screen_pkg::*;
#(
    parameter int         H_ACTIVE = DEF_H_ACTIVE,
    parameter int         H_FP     = DEF_H_FP,
    parameter int         H_SYNC   = DEF_H_SYNC,
    parameter int         H_BP     = DEF_H_BP,
    parameter int         V_ACTIVE = DEF_V_ACTIVE,
    parameter int         V_FP     = DEF_V_FP,
    parameter int         V_SYNC   = DEF_V_SYNC,
    parameter int         V_BP     = DEF_V_BP,
    parameter int         X0       = 256,
    parameter int         Y0       = 176,
    parameter logic [2:0] FG_RGB   = 3'b010,
    parameter logic [2:0] BG_RGB   = 3'b000
) (
    input  logic              clk,
    input  logic              rst,
    output logic              rd_en,
    output logic [RAM_AW-1:0] rd_addr,
    input  logic [RAM_DW-1:0] rd_data,
    output logic              vga_hs,
    output logic              vga_vs,
    output logic              vga_de,
    output logic [2:0]        vga_rgb,
    output logic              frame_start
);

    localparam logic [CNT_W-1:0] WX0 = CNT_W'(X0);
    localparam logic [CNT_W-1:0] WX1 = CNT_W'(X0 + SCR_W);
    localparam logic [CNT_W-1:0] WY0 = CNT_W'(Y0);
    localparam logic [CNT_W-1:0] WY1 = CNT_W'(Y0 + SCR_H);

    logic [CNT_W-1:0] h_cnt, v_cnt;
    logic             hs_raw, vs_raw, de_raw;
    logic [CNT_W-1:0] wx, wy;
    logic             in_win;
    scan_tag_t        tag_now, tag_d1, tag_d2;

    vga_timing_gen #(
        .H_ACTIVE (H_ACTIVE),
        .H_FP     (H_FP),
        .H_SYNC   (H_SYNC),
        .H_BP     (H_BP),
        .V_ACTIVE (V_ACTIVE),
        .V_FP     (V_FP),
        .V_SYNC   (V_SYNC),
        .V_BP     (V_BP)
    ) u_timing (
        .clk    (clk),
        .rst    (rst),
        .h_cnt  (h_cnt),
        .v_cnt  (v_cnt),
        .hs_raw (hs_raw),
        .vs_raw (vs_raw),
        .de_raw (de_raw)
    );

    // Window-relative coordinates; only meaningful while in_win is set.
    assign wx = h_cnt - WX0;
    assign wy = v_cnt - WY0;

    // Gating with de_raw clips a window that spills past the active raster.
    assign in_win = de_raw && (h_cnt >= WX0) && (h_cnt < WX1)
                           && (v_cnt >= WY0) && (v_cnt < WY1);

    assign tag_now = '{hs: hs_raw, vs: vs_raw, de: de_raw, win: in_win,
                       first: (h_cnt == '0) && (v_cnt == '0), bit_idx: wx[2:0]};

    // Stage 1: issue the RAM read; the address holds outside the window.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rd_en   <= 1'b0;
            rd_addr <= '0;
            tag_d1  <= TAG_IDLE;
        end else begin
            rd_en  <= in_win;
            if (in_win) begin
                rd_addr <= scr_addr(wy, wx);
            end
            tag_d1 <= tag_now;
        end
    end

    // Stage 2: wait for the RAM's registered read data.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            tag_d2 <= TAG_IDLE;
        end else begin
            tag_d2 <= tag_d1;
        end
    end

    // Stage 3: register the pins; bit 0 of each byte is the leftmost pixel.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            vga_hs      <= 1'b1;
            vga_vs      <= 1'b1;
            vga_de      <= 1'b0;
            vga_rgb     <= 3'b000;
            frame_start <= 1'b0;
        end else begin
            vga_hs      <= tag_d2.hs;
            vga_vs      <= tag_d2.vs;
            vga_de      <= tag_d2.de;
            frame_start <= tag_d2.first;
            if (!tag_d2.win) begin
                vga_rgb <= 3'b000;
            end else if (rd_data[tag_d2.bit_idx]) begin
                vga_rgb <= FG_RGB;
            end else begin
                vga_rgb <= BG_RGB;
            end
        end
    end

endmodule

// File: tb/tb_screen_scan.sv
// Directed bench for screen_scan using a shrunken raster (144x136 totals) so a
// full frame is short; the 128x128 window sits at (4,2) inside a 136x132 active area.
module tb_screen_scan;

    localparam int HA = 136, HFP = 2, HSW = 4, HBP = 2;
    localparam int VA = 132, VFP = 1, VSW = 2, VBP = 1;
    localparam int HT = HA + HFP + HSW + HBP;   // 144
    localparam int VT = VA + VFP + VSW + VBP;   // 136
    localparam int FR = HT * VT;                // 19584
    localparam int WX = 4, WY = 2;
    localparam logic [2:0] FG = 3'b010, BG = 3'b000;

    logic        clk = 1'b0;
    logic        rst;
    logic        rd_en;
    logic [10:0] rd_addr;
    logic [7:0]  rd_data = 8'h00;
    logic        vga_hs, vga_vs, vga_de, frame_start;
    logic [2:0]  vga_rgb;

    logic [7:0]  ram [2048];

    int n_vec, n_miss;

    // monitor state
    int  cyc = 0;
    bit  trk = 0, cap_arm = 0, cap_on = 0, cap_done = 0;
    int  cap_t0, cap_period;
    int  p, px, py, rp, rx, ry;
    int  fg_cnt, de_cnt, blank_bad, out_bad;
    int  hs_first, hs_cnt, vs_first, vs_cnt;
    int  rd_cnt, rd_out, line_rd, addr_bad;
    logic [2:0] win_pix [128][128];

    screen_scan #(
        .H_ACTIVE (HA), .H_FP (HFP), .H_SYNC (HSW), .H_BP (HBP),
        .V_ACTIVE (VA), .V_FP (VFP), .V_SYNC (VSW), .V_BP (VBP),
        .X0 (WX), .Y0 (WY), .FG_RGB (FG), .BG_RGB (BG)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .rd_en       (rd_en),
        .rd_addr     (rd_addr),
        .rd_data     (rd_data),
        .vga_hs      (vga_hs),
        .vga_vs      (vga_vs),
        .vga_de      (vga_de),
        .vga_rgb     (vga_rgb),
        .frame_start (frame_start)
    );

    always #5 clk = ~clk;

    // display RAM read port: data one clk after the strobe
    always @(posedge clk) begin
        if (rd_en) rd_data <= ram[rd_addr];
    end

    task automatic chk(input string tag, input int got, input int exp);
        n_vec++;
        if (got !== exp) begin
            n_miss++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    // pin-side raster tracker, anchored on frame_start
    always @(negedge clk) begin
        cyc++;
        if (rst) begin
            trk = 0;
        end else begin
            if (frame_start) begin
                if (cap_on) begin
                    cap_on = 0;
                    cap_done = 1;
                    cap_period = cyc - cap_t0;
                end else if (cap_arm) begin
                    cap_arm = 0; cap_on = 1; cap_t0 = cyc;
                    fg_cnt = 0; de_cnt = 0; blank_bad = 0; out_bad = 0;
                    hs_first = -1; hs_cnt = 0; vs_first = -1; vs_cnt = 0;
                    rd_cnt = 0; rd_out = 0; line_rd = 0; addr_bad = 0;
                end
                p = 0;
                trk = 1;
            end else if (trk) begin
                p = (p + 1) % FR;
            end
            px = p % HT;
            py = p / HT;
            if (cap_on) begin
                if (px < HA && py < VA) begin
                    if (vga_de) de_cnt++;
                    if (px >= WX && px < WX + 128 && py >= WY && py < WY + 128)
                        win_pix[py-WY][px-WX] = vga_rgb;
                    else if (vga_rgb != 3'b000)
                        out_bad++;
                end else if (vga_rgb != 3'b000 || vga_de) begin
                    blank_bad++;
                end
                if (vga_rgb == FG) fg_cnt++;
                if (py == 0 && !vga_hs) begin
                    if (hs_first < 0) hs_first = px;
                    hs_cnt++;
                end
                if (px == 0 && !vga_vs) begin
                    if (vs_first < 0) vs_first = py;
                    vs_cnt++;
                end
                // read strobe leads the pins by two clks
                rp = (p + 2) % FR;
                rx = rp % HT;
                ry = rp / HT;
                if (rd_en) begin
                    rd_cnt++;
                    if (!(rx >= WX && rx < WX + 128 && ry >= WY && ry < WY + 128))
                        rd_out++;
                    if (ry == WY + 5) begin
                        line_rd++;
                        if (int'(rd_addr) != 80 + (rx - WX) / 8) addr_bad++;
                    end
                end
            end
        end
    end

    initial begin
        int n;
        n_vec = 0;
        n_miss = 0;
        rst = 1'b1;
        for (int i = 0; i < 2048; i++) ram[i] = 8'h00;
        ram[0]           = 8'h01;
        ram[2047]        = 8'hFF;
        ram[30 * 16 + 2] = 8'b0000_0111;

        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("rst_hs", vga_hs, 1);
        chk("rst_vs", vga_vs, 1);
        chk("rst_de", vga_de, 0);
        chk("rst_rgb", vga_rgb, 0);
        chk("rst_fs", frame_start, 0);
        chk("rst_rd_en", rd_en, 0);
        chk("rst_rd_addr", rd_addr, 0);

        cap_arm = 1;
        rst = 1'b0;
        n = 0;
        while (!frame_start && n < 10) begin
            @(negedge clk);
            n++;
        end
        chk("fs_latency", n, 3);

        n = 0;
        while (!cap_done && n < FR + 100) begin
            @(negedge clk);
            n++;
        end
        chk("frame_done", cap_done, 1);
        chk("frame_period", cap_period, FR);
        chk("fg_count", fg_cnt, 12);
        chk("pix_0_0", win_pix[0][0], FG);
        chk("pix_1_0", win_pix[0][1], BG);
        chk("pix_7_0", win_pix[0][7], BG);
        chk("pix_8_0", win_pix[0][8], BG);
        chk("pix_119_127", win_pix[127][119], BG);
        chk("pix_120_127", win_pix[127][120], FG);
        chk("pix_127_127", win_pix[127][127], FG);
        chk("pix_16_30", win_pix[30][16], FG);
        chk("pix_18_30", win_pix[30][18], FG);
        chk("pix_19_30", win_pix[30][19], BG);
        chk("pix_15_30", win_pix[30][15], BG);
        chk("outside_rgb", out_bad, 0);
        chk("blank_black", blank_bad, 0);
        chk("de_count", de_cnt, HA * VA);
        chk("hs_first", hs_first, HA + HFP);
        chk("hs_width", hs_cnt, HSW);
        chk("vs_first", vs_first, VA + VFP);
        chk("vs_width", vs_cnt, VSW);
        chk("rd_total", rd_cnt, 128 * 128);
        chk("rd_outside", rd_out, 0);
        chk("line5_rd", line_rd, 128);
        chk("line5_addr", addr_bad, 0);

        // mid-frame reset
        n = 0;
        while (!(trk && py == 100 && px == 50) && n < FR + 100) begin
            @(negedge clk);
            n++;
        end
        chk("reach_mid", int'(trk && py == 100 && px == 50), 1);
        chk("mid_de_pre", vga_de, 1);
        #2 rst = 1'b1;
        #1;
        chk("async_de", vga_de, 0);
        chk("async_rgb", vga_rgb, 0);
        chk("async_hs", vga_hs, 1);
        chk("async_vs", vga_vs, 1);
        chk("async_rd_en", rd_en, 0);
        chk("async_rd_addr", rd_addr, 0);
        @(posedge clk);
        @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        n = 0;
        while (!frame_start && n < 10) begin
            @(negedge clk);
            n++;
        end
        chk("restart_latency", n, 3);
        @(negedge clk);
        n = 1;
        while (!frame_start && n < FR + 100) begin
            @(negedge clk);
            n++;
        end
        chk("restart_period", n, FR);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end

endmodule

// File: doc/screen_scan.md
Name: screen_scan

Overview:
- Read-side partner of the HP-bar screen writer.
- Scans the 128x128 monochrome display RAM (2048 bytes, 16 bytes per row, addr = y*16 + x/8) and generates VGA timing.
- Places the bitmap as a window inside the active raster.
- Sits between the dual-port display RAM read port and the VGA pins. clk is the pixel clock.

Parameters:
H_ACTIVE, 640, visible pixels per line
H_FP, 16, horizontal front porch (clocks)
H_SYNC, 96, horizontal sync width (clocks)
H_BP, 48, horizontal back porch (clocks)
V_ACTIVE, 480, visible lines per frame
V_FP, 10, vertical front porch (lines)
V_SYNC, 2, vertical sync width (lines)
V_BP, 33, vertical back porch (lines)
X0, 256, window left column in active raster
Y0, 176, window top line in active raster
FG_RGB, 3'b010, colour of a set bit
BG_RGB, 3'b000, colour of a clear bit inside the window

Ports:
clk  in  1  pixel clock
rst  in  1  asynchronous, active-high reset
rd_en  out  1  RAM read strobe
rd_addr  out  11  RAM read address, y*16 + x/8
rd_data  in  8  RAM read data, valid one clk after rd_en/rd_addr
vga_hs  out  1  horizontal sync, active low
vga_vs  out  1  vertical sync, active low
vga_de  out  1  active-video flag
vga_rgb  out  3  pixel colour
frame_start  out  1  one-clk pulse aligned with first output pixel (0,0)

Behaviour:
- Reset: one clock; reset is asynchronous and active-high. While rst is high:
  - h_cnt = v_cnt = 0.
  - rd_en = 0, rd_addr = 0.
  - vga_hs = vga_vs = 1, vga_de = 0, vga_rgb = 0, frame_start = 0.
  - All pipeline delay registers clear.
- Counters:
  - h_cnt counts 0..H_TOTAL-1, where H_TOTAL = sum of H params (800).
  - v_cnt increments when h_cnt wraps; it wraps at V_TOTAL-1 (524).
  - Active region: h_cnt < H_ACTIVE and v_cnt < V_ACTIVE.
  - hs_raw low for h_cnt in [H_ACTIVE+H_FP, H_ACTIVE+H_FP+H_SYNC-1]. vs_raw follows the same rule on v_cnt.
- Pipeline, counter value at cycle t:
  - t+1: rd_en / rd_addr registered.
  - t+2: rd_data valid.
  - t+3: vga_* outputs registered.
  - hs, vs, de, in_window flag and bit index (h_cnt-X0)[2:0] are delayed 3 clks to stay aligned. Total latency from counter to pins is fixed at 3 clks.
- Window:
  - in_window = active, X0 <= h_cnt < X0+128, and Y0 <= v_cnt < Y0+128.
  - When in_window, rd_en = 1 and rd_addr = ((v_cnt-Y0)<<4) + ((h_cnt-X0)>>3), truncated to 11 bits. Otherwise rd_en = 0 and rd_addr holds its value.
  - Each address is held for 8 consecutive in-window clks.
- Pixel select:
  - Bit 0 of a byte is the leftmost pixel; bit k maps to x = 8*col + k. This matches the writer's fill order, where 8'b0000_0001 is one left pixel.
  - vga_rgb = FG_RGB if the delayed in_window is set and rd_data[bit] = 1.
  - vga_rgb = BG_RGB if the delayed in_window is set and the bit is 0.
  - vga_rgb = 0 when not in window or not in active video (blanking is forced black).
- frame_start: asserted for 1 clk when the delayed (h,v) = (0,0), i.e. concurrent with vga_de rising for the frame's first pixel.
- Writer collisions: the RAM is dual-port. Writes during scan may tear within a frame; no arbitration is required.
- Window clipping: a window overlapping the raster edge (X0+128 > H_ACTIVE) is clipped by the active gate. rd_en is never asserted outside the active region.
- Reset mid-frame: outputs return to reset values immediately. Scanning restarts at (0,0) on the first clk after release, with the first frame_start 3 clks later.

Decomposition:
- Shared package screen_pkg holds:
  - screen constants: SCR_W = 128, SCR_H = 128, BYTES_PER_ROW = 16, RAM_AW = 11, RAM_DW = 8;
  - default 640x480 timing constants;
  - addr = y*16 + x/8 mapping function, reused by the writer.
- One sub-module, vga_timing_gen: h/v counters, raw hs/vs/de, pixel coordinates. screen_scan adds the window, RAM fetch and pipeline alignment.

Test Plan:
- Reset released, RAM all 0 -> vga_hs/vs high during reset; then hs low for h_cnt 656..751 (appears at pins 3 clks later), vs low on lines 490..491; all window pixels BG_RGB; frame_start period exactly 420000 clks.
- addr 0 = 8'h01, rest 0 -> exactly one FG pixel per frame, at active x=256, y=176; pixels x=257..263 are BG.
- addr 2047 = 8'hFF -> FG at x=376..383, y=303 only.
- addr 30*16+2 = 8'b0000_0111 (writer HP bar fragment) -> FG at x=272..274, y=206; x=275 BG.
- Line y = Y0+5 monitored -> rd_addr sequence 80,81,...,95, each held 8 clks; rd_en low outside x 256..383; rd_en never high during blanking.
- rst pulsed for 2 clks at mid-frame v_cnt=300 -> outputs reset asynchronously; first frame_start 3 clks after release; next one 420000 clks later.
